// File: rtl/wb_fib_ctrl.sv
`timescale 1ns/1ps
// Wishbone register block for a bank of Fibonacci channels: per-channel clock select and
// enable, value readback, a scratch FIFO and three maskable interrupt sources.
module wb_fib_ctrl #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          CHANNELS     = 2,
    parameter int          CLOCK_WIDTH  = 6,
    parameter int          VAL_WIDTH    = 30,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_ni,
    input  logic                            wbs_stb_i,
    input  logic                            wbs_cyc_i,
    input  logic                            wbs_we_i,
    input  logic [3:0]                      wbs_sel_i,
    input  logic [31:0]                     wbs_adr_i,
    input  logic [31:0]                     wbs_dat_i,
    output logic                            wbs_ack_o,
    output logic [31:0]                     wbs_dat_o,
    input  logic [CHANNELS*VAL_WIDTH-1:0]   chan_val_i,
    output logic [CHANNELS*CLOCK_WIDTH-1:0] clock_op,
    output logic [CHANNELS-1:0]             switch_out,
    output logic [2:0]                      irq_out
);
    localparam int          PTR_W    = $clog2(FIFO_DEPTH);
    localparam int          CNT_W    = PTR_W + 1;
    localparam logic [31:0] LAST_OFF = 32'h24 + 32'(8 * (CHANNELS - 1));
    localparam logic [31:0] NR_VALUE = 32'(8 + 2 * CHANNELS);
    localparam logic [31:0] ID_VALUE = 32'h4669_6232;

    typedef enum logic [3:0] {
        R_NR, R_ID, R_STAT, R_MASK, R_CTRL, R_FIFO, R_FSTAT, R_FLUSH, R_CLOCK, R_VAL, R_HOLE
    } reg_e;

    logic [31:0]            offset;
    logic                   in_window, access, full_wr, writable;
    reg_e                   reg_sel;
    logic [1:0]             chan_sel;
    logic [31:0]            rd_data, dat_d;

    logic [CHANNELS-1:0]    switch_q;
    logic [CLOCK_WIDTH-1:0] clock_q [CHANNELS];
    logic [2:0]             irq_mask_q, irq_stat;
    logic                   ovf_q, wrap_q, ovf_evt, wrap_evt;
    logic [1:0]             stat_clr;
    logic [CHANNELS-1:0]    msb_now, msb_q;

    logic [31:0]            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   fifo_empty, fifo_full, push, pop, push_ok, pop_ok, flush;

    // A new access is only taken while ack is low, so back-to-back cycles alternate.
    assign offset    = wbs_adr_i - BASE_ADDRESS;
    assign in_window = (wbs_adr_i >= BASE_ADDRESS) && (offset <= LAST_OFF);
    assign access    = wbs_stb_i && wbs_cyc_i && !wbs_ack_o && in_window;
    assign full_wr   = wbs_we_i && (wbs_sel_i == 4'hF);
    assign chan_sel  = offset[4:3];

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        reg_sel = R_HOLE;
        if (offset[1:0] == 2'b00) begin
            if (offset[7:5] == 3'b001) begin
                reg_sel = offset[2] ? R_VAL : R_CLOCK;
            end else if (offset[7:5] == 3'b000) begin
                case (offset[4:2])
                    3'd0: reg_sel = R_NR;
                    3'd1: reg_sel = R_ID;
                    3'd2: reg_sel = R_STAT;
                    3'd3: reg_sel = R_MASK;
                    3'd4: reg_sel = R_CTRL;
                    3'd5: reg_sel = R_FIFO;
                    3'd6: reg_sel = R_FSTAT;
                    3'd7: reg_sel = R_FLUSH;
                endcase
            end
        end
    end

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign irq_stat   = {wrap_q, ovf_q, !fifo_empty};

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            R_NR:    rd_data = NR_VALUE;
            R_ID:    rd_data = ID_VALUE;
            R_STAT:  rd_data[2:0] = irq_stat;
            R_MASK:  rd_data[2:0] = irq_mask_q;
            R_CTRL:  rd_data[CHANNELS-1:0] = switch_q;
            R_FIFO:  if (!fifo_empty) rd_data = fifo_mem[rd_ptr];
            R_FSTAT: rd_data = {16'(count), 14'b0, fifo_full, fifo_empty};
            R_CLOCK, R_VAL: begin
                for (int n = 0; n < CHANNELS; n++) begin
                    if (chan_sel == 2'(n)) begin
                        rd_data = (reg_sel == R_CLOCK) ? 32'(clock_q[n])
                                                       : 32'(chan_val_i[n*VAL_WIDTH +: VAL_WIDTH]);
                    end
                end
            end
            default: rd_data = '0;
        endcase
    end

    assign writable = reg_sel inside {R_STAT, R_MASK, R_CTRL, R_FIFO, R_FLUSH, R_CLOCK};
    assign dat_d    = wbs_we_i ? {31'b0, full_wr && writable} : rd_data;

    assign push     = access && full_wr && (reg_sel == R_FIFO);
    assign pop      = access && !wbs_we_i && (reg_sel == R_FIFO);
    assign flush    = access && full_wr && (reg_sel == R_FLUSH);
    assign push_ok  = push && !fifo_full;
    assign pop_ok   = pop && !fifo_empty;
    assign ovf_evt  = (push && fifo_full) || (pop && fifo_empty);
    assign stat_clr = (access && full_wr && (reg_sel == R_STAT)) ? wbs_dat_i[2:1] : 2'b00;

    always_comb begin
        msb_now = '0;
        for (int n = 0; n < CHANNELS; n++) msb_now[n] = chan_val_i[n*VAL_WIDTH + VAL_WIDTH - 1];
    end
    assign wrap_evt = |(msb_q & ~msb_now & switch_q);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= access;
            if (access) wbs_dat_o <= dat_d;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            switch_q   <= '1;
            irq_mask_q <= '0;
            for (int n = 0; n < CHANNELS; n++) clock_q[n] <= CLOCK_WIDTH'(1);
        end else if (access && full_wr) begin
            case (reg_sel)
                R_MASK:  irq_mask_q <= wbs_dat_i[2:0];
                R_CTRL:  switch_q   <= wbs_dat_i[CHANNELS-1:0];
                R_CLOCK: begin
                    for (int n = 0; n < CHANNELS; n++) begin
                        if (chan_sel == 2'(n)) clock_q[n] <= wbs_dat_i[CLOCK_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky sources: a set event in the same cycle as a W1C clear wins.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            msb_q   <= '0;
            ovf_q   <= 1'b0;
            wrap_q  <= 1'b0;
            irq_out <= '0;
        end else begin
            msb_q   <= msb_now;
            ovf_q   <= ovf_evt  || (ovf_q  && !stat_clr[0]);
            wrap_q  <= wrap_evt || (wrap_q && !stat_clr[1]);
            irq_out <= irq_stat & irq_mask_q;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            count  <= count + CNT_W'(1);
        end else if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count - CNT_W'(1);
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone define its contents.
    always_ff @(posedge wb_clk_i) begin
        if (push_ok) fifo_mem[wr_ptr] <= wbs_dat_i;
    end

    always_comb begin
        clock_op = '0;
        for (int n = 0; n < CHANNELS; n++) clock_op[n*CLOCK_WIDTH +: CLOCK_WIDTH] = clock_q[n];
    end
    assign switch_out = switch_q;

endmodule

// File: tb/tb_wb_fib_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for wb_fib_ctrl: directed steps from the requirements followed by
// random bus traffic compared against a register-level reference model.
module tb_wb_fib_ctrl;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int CH = 2;
    localparam int CW = 6;
    localparam int VW = 30;
    localparam int FD = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]        sel = 4'h0;
    logic [31:0]       adr = '0, wdat = '0;
    logic              ack;
    logic [31:0]       rdat;
    logic [CH*VW-1:0]  chan_val = '0;
    logic [CH*CW-1:0]  clock_op;
    logic [CH-1:0]     switch_out;
    logic [2:0]        irq_out;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0]      m_fifo[$];
    logic [CH-1:0]    m_switch;
    logic [CW-1:0]    m_clock [CH];
    logic [2:0]       m_mask;
    logic             m_ovf, m_wrap;
    logic [CH*VW-1:0] m_chan = '0;

    wb_fib_ctrl #(
        .BASE_ADDRESS(BASE), .CHANNELS(CH), .CLOCK_WIDTH(CW), .VAL_WIDTH(VW), .FIFO_DEPTH(FD)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .chan_val_i (chan_val),
        .clock_op   (clock_op),
        .switch_out (switch_out),
        .irq_out    (irq_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_switch = '1;
        for (int n = 0; n < CH; n++) m_clock[n] = CW'(1);
        m_mask = '0;
        m_ovf  = 1'b0;
        m_wrap = 1'b0;
    endtask

    function automatic logic [2:0] model_stat();
        return {m_wrap, m_ovf, m_fifo.size() != 0};
    endfunction

    function automatic logic [31:0] model_clock_op();
        logic [31:0] v = '0;
        for (int n = 0; n < CH; n++) v[n*CW +: CW] = m_clock[n];
        return v;
    endfunction

    // Predicts ack/data of one access from the register map and applies its side effects.
    task automatic model_access(input logic [31:0] addr, input logic w, input logic [3:0] s,
                                input logic [31:0] d, output bit exp_ack, output logic [31:0] exp_dat);
        logic [31:0] off;
        bit full;
        int n;
        off = addr - BASE;
        full = w && (s == 4'hF);
        exp_dat = '0;
        exp_ack = (addr >= BASE) && (off <= 32'h24 + 32'(8 * (CH - 1)));
        if (!exp_ack || off[1:0] != 2'b00) return;
        if (off >= 32'h20) begin
            n = int'((off - 32'h20) >> 3);
            if (off[2]) begin
                if (!w) exp_dat = 32'(m_chan[n*VW +: VW]);
            end else if (w) begin
                if (full) begin
                    m_clock[n] = d[CW-1:0];
                    exp_dat = 32'h1;
                end
            end else begin
                exp_dat = 32'(m_clock[n]);
            end
            return;
        end
        case (off)
            32'h00: if (!w) exp_dat = 32'(8 + 2 * CH);
            32'h04: if (!w) exp_dat = 32'h4669_6232;
            32'h08: begin
                if (!w) exp_dat = 32'(model_stat());
                else if (full) begin
                    if (d[1]) m_ovf = 1'b0;
                    if (d[2]) m_wrap = 1'b0;
                    exp_dat = 32'h1;
                end
            end
            32'h0C: begin
                if (!w) exp_dat = 32'(m_mask);
                else if (full) begin
                    m_mask = d[2:0];
                    exp_dat = 32'h1;
                end
            end
            32'h10: begin
                if (!w) exp_dat = 32'(m_switch);
                else if (full) begin
                    m_switch = d[CH-1:0];
                    exp_dat = 32'h1;
                end
            end
            32'h14: begin
                if (w) begin
                    if (full) begin
                        if (m_fifo.size() == FD) m_ovf = 1'b1;
                        else m_fifo.push_back(d);
                        exp_dat = 32'h1;
                    end
                end else if (m_fifo.size() == 0) begin
                    m_ovf = 1'b1;
                end else begin
                    exp_dat = m_fifo.pop_front();
                end
            end
            32'h18: if (!w) exp_dat = {16'(m_fifo.size()), 14'b0, m_fifo.size() == FD, m_fifo.size() == 0};
            32'h1C: if (full) begin
                m_fifo.delete();
                exp_dat = 32'h1;
            end
            default: ;
        endcase
    endtask

    task automatic bus(input logic [31:0] addr, input logic w, input logic [3:0] s,
                       input logic [31:0] d, input string tag);
        bit exp_ack, got;
        logic [31:0] exp_dat, got_dat;
        int lat;
        model_access(addr, w, s, d, exp_ack, exp_dat);
        adr = addr; we = w; sel = s; wdat = d; stb = 1'b1; cyc = 1'b1;
        got = 1'b0; got_dat = '0; lat = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ack) begin
                got = 1'b1;
                got_dat = rdat;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        check({tag, " ack"}, 32'(got), 32'(exp_ack));
        if (got && exp_ack) begin
            check({tag, " latency"}, 32'(lat), 32'd1);
            check({tag, " data"}, got_dat, exp_dat);
        end
        @(posedge clk); #1;
        if (got) check({tag, " ack width"}, 32'(ack), 32'd0);
        check({tag, " irq_out"}, 32'(irq_out), 32'(model_stat() & m_mask));
    endtask

    task automatic set_chan(input logic [CH*VW-1:0] v);
        for (int n = 0; n < CH; n++) begin
            if (m_chan[n*VW + VW - 1] && !v[n*VW + VW - 1] && m_switch[n]) m_wrap = 1'b1;
        end
        m_chan = v;
        chan_val = v;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [CH*VW-1:0] v;
        logic [31:0] a, d;
        logic [31:0] offs [14];
        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h14, 32'h14,
                 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C};
        model_reset();

        // Reset state
        #23;
        check("reset ack", 32'(ack), 32'd0);
        check("reset dat", rdat, 32'd0);
        check("reset irq_out", 32'(irq_out), 32'd0);
        check("reset switch_out", 32'(switch_out), 32'h3);
        check("reset clock_op", 32'(clock_op), 32'h041);
        @(negedge clk);
        rst_n = 1'b1;

        // Identification registers
        bus(BASE + 32'h04, 1'b0, 4'hF, 32'h0, "read ID");
        bus(BASE + 32'h00, 1'b0, 4'hF, 32'h0, "read NR");

        // Clock selects
        bus(BASE + 32'h20, 1'b1, 4'hF, 32'h2A, "write CLOCK0");
        bus(BASE + 32'h28, 1'b1, 4'hF, 32'h05, "write CLOCK1");
        check("clock_op after writes", 32'(clock_op), 32'h16A);
        bus(BASE + 32'h20, 1'b0, 4'hF, 32'h0, "read CLOCK0");
        bus(BASE + 32'h28, 1'b0, 4'hF, 32'h0, "read CLOCK1");
        bus(BASE + 32'h04, 1'b1, 4'hF, 32'h1234, "write RO ID");

        // FIFO overflow and underflow
        for (int i = 1; i <= 5; i++) bus(BASE + 32'h14, 1'b1, 4'hF, 32'(i * 32'h11), "push");
        bus(BASE + 32'h18, 1'b0, 4'hF, 32'h0, "FIFO_STAT full");
        bus(BASE + 32'h08, 1'b0, 4'hF, 32'h0, "IRQ_STAT ovf");
        for (int i = 1; i <= 5; i++) bus(BASE + 32'h14, 1'b0, 4'hF, 32'h0, "pop");
        bus(BASE + 32'h08, 1'b1, 4'hF, 32'h2, "W1C ovf");

        // Wrap interrupt with channel 0 enabled then disabled
        bus(BASE + 32'h0C, 1'b1, 4'hF, 32'h7, "write MASK");
        set_chan(60'(1) << (VW - 1));
        set_chan('0);
        @(posedge clk); #1;
        check("wrap irq_out[2]", 32'(irq_out[2]), 32'd1);
        bus(BASE + 32'h08, 1'b1, 4'hF, 32'h4, "W1C wrap");
        bus(BASE + 32'h08, 1'b0, 4'hF, 32'h0, "IRQ_STAT cleared");
        bus(BASE + 32'h10, 1'b1, 4'hF, 32'h2, "disable ch0");
        set_chan(60'(1) << (VW - 1));
        set_chan('0);
        @(posedge clk); #1;
        check("disabled irq_out[2]", 32'(irq_out[2]), 32'd0);
        bus(BASE + 32'h08, 1'b0, 4'hF, 32'h0, "IRQ_STAT disabled ch");
        bus(BASE + 32'h10, 1'b1, 4'hF, 32'h3, "enable all");

        // Out-of-window and partial select
        bus(BASE + 32'h100, 1'b0, 4'hF, 32'h0, "out of window");
        bus(BASE + 32'h10, 1'b1, 4'h3, 32'h0, "partial CTRL write");
        check("switch_out after partial", 32'(switch_out), 32'(m_switch));
        bus(BASE + 32'h10, 1'b0, 4'hF, 32'h0, "read CTRL");

        // Reset in the middle of an access with two words queued
        bus(BASE + 32'h14, 1'b1, 4'hF, 32'hA5A5_0001, "push pre-reset");
        bus(BASE + 32'h14, 1'b1, 4'hF, 32'hA5A5_0002, "push pre-reset");
        bus(BASE + 32'h10, 1'b1, 4'hF, 32'h0, "CTRL clear pre-reset");
        adr = BASE + 32'h18; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
        @(posedge clk); #1;
        check("ack before reset", 32'(ack), 32'd1);
        rst_n = 1'b0;
        #1;
        check("ack in reset", 32'(ack), 32'd0);
        check("dat in reset", rdat, 32'd0);
        check("irq_out in reset", 32'(irq_out), 32'd0);
        stb = 1'b0; cyc = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        check("switch_out after reset", 32'(switch_out), 32'h3);
        check("clock_op after reset", 32'(clock_op), model_clock_op());
        bus(BASE + 32'h18, 1'b0, 4'hF, 32'h0, "FIFO_STAT after reset");
        bus(BASE + 32'h14, 1'b0, 4'hF, 32'h0, "pop empty after reset");

        // Random traffic against the model
        for (int k = 0; k < 300; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
                for (int n = 0; n < CH; n++) v[n*VW +: VW] = VW'($urandom());
                set_chan(v);
            end else begin
                if (r < 10) a = BASE + 32'h30 + 32'($urandom_range(0, 32'hD0));
                else if (r < 14) a = BASE + offs[$urandom_range(0, 13)] + 32'($urandom_range(1, 3));
                else a = BASE + offs[$urandom_range(0, 13)];
                d = $urandom();
                bus(a, 1'($urandom()), ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF, d, "random");
            end
        end
        check("final clock_op", 32'(clock_op), model_clock_op());
        check("final switch_out", 32'(switch_out), 32'(m_switch));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_fib_ctrl.md
WB_FIB_CTRL -- requirements
Module: wb_fib_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h30000000, Wishbone base of the register window.
REQ-002 SHALL have parameter CHANNELS, default 2, number of Fibonacci channels (1..4).
REQ-003 SHALL have parameter CLOCK_WIDTH, default 6, per-channel clock-select width.
REQ-004 SHALL have parameter VAL_WIDTH, default 30, per-channel value width (<=32).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, scratch FIFO entries (power of two, >=2).
REQ-006 SHALL have ports, one clock, reset asynchronous and active-low:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  async active-low reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write-enable.
- wbs_sel_i  in  4  byte selects.
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- chan_val_i  in  CHANNELS*VAL_WIDTH  channel values, channel 0 in LSBs.
- clock_op  out  CHANNELS*CLOCK_WIDTH  per-channel clock select.
- switch_out  out  CHANNELS  per-channel enable.
- irq_out  out  3  interrupt lines.

Function
REQ-007 SHALL decode word offsets from BASE_ADDRESS:
- 0x00 NR (RO) = 8+2*CHANNELS.
- 0x04 ID (RO) = 32'h46696232.
- 0x08 IRQ_STAT (W1C).
- 0x0C IRQ_MASK (RW, bits[2:0]).
- 0x10 CTRL (RW, bits[CHANNELS-1:0] = switch_out).
- 0x14 FIFO data (write pushes, read pops).
- 0x18 FIFO_STAT (RO) = {count[15:0], 14'b0, full, empty}.
- 0x1C FIFO_FLUSH (WO, any value clears FIFO).
- 0x20+8*n CLOCK channel n (RW, CLOCK_WIDTH LSBs).
- 0x24+8*n VAL channel n (RO, zero-extended chan_val_i slice).
REQ-008 SHALL assert wbs_ack_o for exactly one cycle, the cycle after stb&cyc sampled high with ack low, for addresses inside the window (0x00..0x24+8*(CHANNELS-1)).
REQ-009 SHALL never ack outside the window; bus hangs by design; no state change.
REQ-010 SHALL not accept a new access while ack is high (back-to-back accesses complete every second cycle).
REQ-011 SHALL register read data into wbs_dat_o together with ack; unmapped in-window holes and WO registers read 0.
REQ-012 SHALL perform writes only when wbs_sel_i==4'hF; partial-select writes are acked, change nothing, return 0.
REQ-013 SHALL return 32'h1 on wbs_dat_o for accepted full writes, 0 for writes to RO registers.
REQ-014 SHALL implement FIFO_DEPTH x 32 FIFO with wrapping pointers and count 0..FIFO_DEPTH.
REQ-015 SHALL on push when full drop data and set IRQ_STAT[1] (overflow); on pop when empty return 0 and set IRQ_STAT[1].
REQ-016 SHALL set IRQ_STAT[0] while FIFO non-empty (level, not clearable by W1C).
REQ-017 SHALL set IRQ_STAT[2] when any enabled channel's value MSB falls 1->0 (wrap), sampled each cycle against a registered copy.
REQ-018 SHALL on IRQ_STAT write clear bits written 1 (bits 1,2); a same-cycle set event wins over clear.
REQ-019 SHALL drive irq_out = IRQ_STAT[2:0] & IRQ_MASK[2:0], registered.
REQ-020 SHALL on FIFO_FLUSH zero pointers and count in the ack cycle; flush has priority over nothing else since accesses are exclusive.

Reset
REQ-021 SHALL on wb_rst_ni low, asynchronously: wbs_ack_o=0, wbs_dat_o=0, irq_out=0, IRQ_STAT=0, IRQ_MASK=0, FIFO empty, switch_out all 1, each clock_op field = 1.
REQ-022 SHALL abandon any in-flight access on reset; no ack is issued for it after release.
REQ-023 SHALL respond to a new access starting the first clock edge after reset release.

Verification
REQ-024 Read 0x04 then 0x00 with CHANNELS=2 -> 32'h46696232, then 32'h0000000C, each ack one cycle wide.
REQ-025 Write 0x20=0x2A, 0x28=0x05, read back -> clock_op = {6'h05,6'h2A}, reads 0x2A, 0x05.
REQ-026 Push 5 words into FIFO_DEPTH=4 -> FIFO_STAT = {16'd4,...,full=1}, IRQ_STAT[1]=1; pops return first four in order; 5th pop returns 0.
REQ-027 IRQ_MASK=7, chan_val_i ch0 MSB 1->0 with ch0 enabled -> irq_out[2]=1 within 2 cycles; W1C 0x4 clears; same with ch0 disabled -> no IRQ.
REQ-028 Access address BASE+0x100 -> no ack for 20 cycles; partial-sel write to 0x10 -> ack, CTRL unchanged.
REQ-029 Assert wb_rst_ni low mid-access with FIFO holding 2 words -> ack 0 immediately, FIFO empty, switch_out all 1 after release.
